// File: rtl/decode_pkg.sv
// Shared types and encodings for the decode stage: control bundle, result and immediate selects.
package decode_pkg;

    typedef struct packed {
        logic [4:0] alu_control;
        logic [1:0] alu_mux_src;
        logic [1:0] result_src;
        logic [2:0] branch_src;
        logic       mem_write;
        logic       reg_write;
        logic       branch_valid;
    } ctrl_t;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] SRC_REG    = 2'b00;
    localparam logic [1:0] SRC_IMM    = 2'b01;
    localparam logic [1:0] SRC_PC_IMM = 2'b10;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_SUB    = 5'b01000;
    localparam logic [4:0] ALU_PASS_B = 5'b10000;

    // branch_src reuses func3 for conditional branches; 010/011 are free there
    localparam logic [2:0] BR_JAL  = 3'b010;
    localparam logic [2:0] BR_JALR = 3'b011;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/control_unit.sv
// RV32I main decoder: opcode/func fields to the control bundle and immediate format select.
module control_unit
    import decode_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic       func7b5,
    output ctrl_t      ctrl,
    output logic [2:0] imm_src
);

    always_comb begin
        ctrl    = CTRL_BUBBLE;
        imm_src = IMM_I;
        case (opcode)
            OP_R: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_control = {1'b0, func7b5, func3};
            end
            OP_I: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_mux_src = SRC_IMM;
                // only srai carries a meaningful func7 bit among immediate ops
                ctrl.alu_control = {1'b0, (func3 == 3'b101) & func7b5, func3};
            end
            OP_LOAD: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_mux_src = SRC_IMM;
                ctrl.result_src  = RES_MEM;
                ctrl.alu_control = ALU_ADD;
            end
            OP_STORE: begin
                ctrl.mem_write   = 1'b1;
                ctrl.alu_mux_src = SRC_IMM;
                ctrl.alu_control = ALU_ADD;
                imm_src          = IMM_S;
            end
            OP_BRANCH: begin
                ctrl.branch_valid = 1'b1;
                ctrl.branch_src   = func3;
                ctrl.alu_control  = ALU_SUB;
                imm_src           = IMM_B;
            end
            OP_JAL: begin
                ctrl.reg_write    = 1'b1;
                ctrl.result_src   = RES_PC4;
                ctrl.branch_valid = 1'b1;
                ctrl.branch_src   = BR_JAL;
                imm_src           = IMM_J;
            end
            OP_JALR: begin
                ctrl.reg_write    = 1'b1;
                ctrl.result_src   = RES_PC4;
                ctrl.branch_valid = 1'b1;
                ctrl.branch_src   = BR_JALR;
                ctrl.alu_mux_src  = SRC_IMM;
                ctrl.alu_control  = ALU_ADD;
            end
            OP_LUI: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_mux_src = SRC_IMM;
                ctrl.alu_control = ALU_PASS_B;
                imm_src          = IMM_U;
            end
            OP_AUIPC: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_mux_src = SRC_PC_IMM;
                ctrl.alu_control = ALU_ADD;
                imm_src          = IMM_U;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/reg_file_bypass.sv
// Register file with asynchronous clear, write-through read bypass and a debug read port.
module reg_file_bypass #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_WIDTH  = 5,
    parameter int unsigned DEBUG_REG  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_WIDTH-1:0]  rs1,
    input  logic [REG_WIDTH-1:0]  rs2,
    input  logic                  we,
    input  logic [REG_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam int unsigned NumRegs = 2 ** REG_WIDTH;
    localparam logic [REG_WIDTH-1:0] DbgIdx = REG_WIDTH'(DEBUG_REG);

    logic [DATA_WIDTH-1:0] regs_q [NumRegs];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            regs_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1 != '0) rd1 = (we && waddr == rs1) ? wdata : regs_q[rs1];
        if (rs2 != '0) rd2 = (we && waddr == rs2) ? wdata : regs_q[rs2];
    end

    assign dbg_data = regs_q[DbgIdx];

endmodule

// File: rtl/sign_extend.sv
// Immediate extraction for I/S/B/U/J formats, sign-extended to DATA_WIDTH.
module sign_extend
    import decode_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [31:7]           ins,
    input  logic [2:0]            imm_src,
    output logic [DATA_WIDTH-1:0] imm
);

    logic signed [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_src)
            IMM_I: imm32 = {{20{ins[31]}}, ins[31:20]};
            IMM_S: imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B: imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U: imm32 = {ins[31:12], 12'b0};
            IMM_J: imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = DATA_WIDTH'(imm32);

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage with registered ID/EX boundary, load-use stall, branch flush and perf counters.
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned REG_WIDTH  = 5,
    parameter int unsigned DEBUG_REG  = 10,
    parameter int unsigned PERF_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_valid,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic [PC_WIDTH-1:0]   pc,
    input  logic [PC_WIDTH-1:0]   pc_plus4,
    input  logic                  flush,
    input  logic                  wb_en,
    input  logic [REG_WIDTH-1:0]  wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  id_stall,
    output logic                  ex_valid,
    output logic [DATA_WIDTH-1:0] ex_read_data1,
    output logic [DATA_WIDTH-1:0] ex_read_data2,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic [PC_WIDTH-1:0]   ex_pc,
    output logic [PC_WIDTH-1:0]   ex_pc_plus4,
    output logic [REG_WIDTH-1:0]  ex_rs1,
    output logic [REG_WIDTH-1:0]  ex_rs2,
    output logic [REG_WIDTH-1:0]  ex_rd,
    output logic [2:0]            ex_func3,
    output ctrl_t                 ex_ctrl,
    output logic [PERF_WIDTH-1:0] stall_count,
    output logic [PERF_WIDTH-1:0] flush_count,
    output logic [DATA_WIDTH-1:0] a0
);

    logic [REG_WIDTH-1:0]  rs1, rs2, rd;
    logic [2:0]            func3;
    logic [DATA_WIDTH-1:0] rd1, rd2, imm;
    logic [2:0]            imm_src;
    ctrl_t                 ctrl;
    logic                  hazard, issue;

    assign rs1   = ins[15 +: REG_WIDTH];
    assign rs2   = ins[20 +: REG_WIDTH];
    assign rd    = ins[7 +: REG_WIDTH];
    assign func3 = ins[14:12];

    reg_file_bypass #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_WIDTH  (REG_WIDTH),
        .DEBUG_REG  (DEBUG_REG)
    ) u_reg_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1      (rs1),
        .rs2      (rs2),
        .we       (wb_en),
        .waddr    (wb_addr),
        .wdata    (wb_data),
        .rd1      (rd1),
        .rd2      (rd2),
        .dbg_data (a0)
    );

    control_unit u_control (
        .opcode  (ins[6:0]),
        .func3   (func3),
        .func7b5 (ins[30]),
        .ctrl    (ctrl),
        .imm_src (imm_src)
    );

    sign_extend #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sign_extend (
        .ins     (ins[31:7]),
        .imm_src (imm_src),
        .imm     (imm)
    );

    // rs fields are compared for every format; spurious U/J stalls are harmless
    assign hazard = if_valid && ex_valid && ex_ctrl.result_src == RES_MEM && ex_ctrl.reg_write
                    && ex_rd != '0 && (ex_rd == rs1 || ex_rd == rs2);
    assign id_stall = hazard && !flush;
    assign issue    = if_valid && !flush && !hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_read_data1 <= '0;
            ex_read_data2 <= '0;
            ex_imm        <= '0;
            ex_pc         <= '0;
            ex_pc_plus4   <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_rd         <= '0;
            ex_func3      <= '0;
            ex_ctrl       <= CTRL_BUBBLE;
        end else if (issue) begin
            ex_valid      <= 1'b1;
            ex_read_data1 <= rd1;
            ex_read_data2 <= rd2;
            ex_imm        <= imm;
            ex_pc         <= pc;
            ex_pc_plus4   <= pc_plus4;
            ex_rs1        <= rs1;
            ex_rs2        <= rs2;
            ex_rd         <= rd;
            ex_func3      <= func3;
            ex_ctrl       <= ctrl;
        end else begin
            ex_valid      <= 1'b0;
            ex_read_data1 <= '0;
            ex_read_data2 <= '0;
            ex_imm        <= '0;
            ex_pc         <= '0;
            ex_pc_plus4   <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_rd         <= '0;
            ex_func3      <= '0;
            ex_ctrl       <= CTRL_BUBBLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (id_stall && stall_count != '1) stall_count <= stall_count + 1'b1;
            if (flush && if_valid && flush_count != '1) flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed self-checking bench for decode_stage_pipe with hand-computed expectations.
module tb_decode_stage_pipe;
    import decode_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned PW = 32;
    localparam int unsigned RW = 5;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_valid = 1'b0;
    logic [DW-1:0] ins = '0;
    logic [PW-1:0] pc = '0;
    logic [PW-1:0] pc_plus4 = '0;
    logic          flush = 1'b0;
    logic          wb_en = 1'b0;
    logic [RW-1:0] wb_addr = '0;
    logic [DW-1:0] wb_data = '0;
    logic          id_stall;
    logic          ex_valid;
    logic [DW-1:0] ex_read_data1, ex_read_data2, ex_imm;
    logic [PW-1:0] ex_pc, ex_pc_plus4;
    logic [RW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [2:0]    ex_func3;
    ctrl_t         ex_ctrl;
    logic [CW-1:0] stall_count, flush_count;
    logic [DW-1:0] a0;

    int n_checks = 0;
    int n_errors = 0;
    int exp_stalls;

    decode_stage_pipe #(
        .DATA_WIDTH (DW),
        .PC_WIDTH   (PW),
        .REG_WIDTH  (RW),
        .DEBUG_REG  (10),
        .PERF_WIDTH (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_valid      (if_valid),
        .ins           (ins),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .flush         (flush),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .id_stall      (id_stall),
        .ex_valid      (ex_valid),
        .ex_read_data1 (ex_read_data1),
        .ex_read_data2 (ex_read_data2),
        .ex_imm        (ex_imm),
        .ex_pc         (ex_pc),
        .ex_pc_plus4   (ex_pc_plus4),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .ex_rd         (ex_rd),
        .ex_func3      (ex_func3),
        .ex_ctrl       (ex_ctrl),
        .stall_count   (stall_count),
        .flush_count   (flush_count),
        .a0            (a0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Return 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] word, input logic valid);
        ins      = word;
        if_valid = valid;
    endtask

    initial begin
        #2;
        check("reset ex_valid", ex_valid, 0);
        check("reset id_stall", id_stall, 0);
        check("reset stall_count", stall_count, 0);
        check("reset flush_count", flush_count, 0);
        check("reset ex_rd", ex_rd, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // addi x5,x0,7
        present(32'h0070_0293, 1'b1);
        pc = 32'h100;
        pc_plus4 = 32'h104;
        #1 check("addi stall", id_stall, 0);
        tick();
        check("addi ex_valid", ex_valid, 1);
        check("addi ex_rd", ex_rd, 5);
        check("addi ex_imm", ex_imm, 7);
        check("addi reg_write", ex_ctrl.reg_write, 1);
        check("addi rd1", ex_read_data1, 0);
        check("addi ex_pc", ex_pc, 32'h100);
        check("addi ex_pc4", ex_pc_plus4, 32'h104);
        check("addi ex_rs2", ex_rs2, 7);

        // addi x5,x0,-1
        present(32'hFFF0_0293, 1'b1);
        tick();
        check("addi neg imm", ex_imm, 32'hFFFF_FFFF);

        // invalid slot becomes a bubble
        present(32'hFFF0_0293, 1'b0);
        tick();
        check("idle ex_valid", ex_valid, 0);
        check("idle ex_rd", ex_rd, 0);
        check("idle ex_imm", ex_imm, 0);
        check("idle reg_write", ex_ctrl.reg_write, 0);

        // add x1,x3,x0 with same-cycle write of x3
        present(32'h0001_80B3, 1'b1);
        wb_en = 1'b1;
        wb_addr = 5'd3;
        wb_data = 32'hDEAD_BEEF;
        tick();
        wb_en = 1'b0;
        check("bypass rd1", ex_read_data1, 32'hDEAD_BEEF);
        check("bypass ex_rd", ex_rd, 1);

        // add x8,x3,x0 reads stored x3
        present(32'h0001_8433, 1'b1);
        tick();
        check("stored x3", ex_read_data1, 32'hDEAD_BEEF);
        check("x0 rd2", ex_read_data2, 0);

        // lw x6,0(x2) then add x7,x6,x1
        present(32'h0001_2303, 1'b1);
        #1 check("lw stall", id_stall, 0);
        tick();
        check("lw ex_valid", ex_valid, 1);
        check("lw result_src", ex_ctrl.result_src, RES_MEM);
        check("lw ex_rd", ex_rd, 6);
        present(32'h0013_03B3, 1'b1);
        #1 check("use stall", id_stall, 1);
        tick();
        check("use bubble", ex_valid, 0);
        check("use stall_count", stall_count, 1);
        #1 check("use stall released", id_stall, 0);
        tick();
        check("use issue valid", ex_valid, 1);
        check("use issue rd", ex_rd, 7);
        check("use stall_count hold", stall_count, 1);

        // load-use together with flush
        present(32'h0001_2303, 1'b1);
        tick();
        present(32'h0013_03B3, 1'b1);
        flush = 1'b1;
        #1 check("flush stall", id_stall, 0);
        tick();
        flush = 1'b0;
        check("flush bubble", ex_valid, 0);
        check("flush reg_write", ex_ctrl.reg_write, 0);
        check("flush_count", flush_count, 1);
        check("flush stall_count", stall_count, 1);

        // add x9,x0,x0 with write to x0
        present(32'h0000_04B3, 1'b1);
        wb_en = 1'b1;
        wb_addr = 5'd0;
        wb_data = 32'h55;
        tick();
        wb_en = 1'b0;
        check("x0 bypass rd1", ex_read_data1, 0);
        tick();
        check("x0 stored rd1", ex_read_data1, 0);

        // a0 mirrors x10
        present(32'h0000_04B3, 1'b0);
        wb_en = 1'b1;
        wb_addr = 5'd10;
        wb_data = 32'h1234;
        #1 check("a0 before", a0, 0);
        tick();
        wb_en = 1'b0;
        check("a0 after", a0, 32'h1234);
        present(32'h0005_05B3, 1'b1);
        tick();
        check("x10 read", ex_read_data1, 32'h1234);

        // lw x6,0(x6) held: stalls every other cycle, counter saturates
        exp_stalls = 1;
        present(32'h0003_2303, 1'b1);
        for (int k = 0; k < 40; k++) begin
            #1 check("sat stall", id_stall, (k % 2) == 1);
            if (k == 20) check("sat mid count", stall_count, 11);
            if ((k % 2) == 1) exp_stalls++;
            tick();
        end
        check("sat count", stall_count, (exp_stalls > 15) ? 15 : exp_stalls);
        check("sat flush_count", flush_count, 1);

        // asynchronous reset in the middle of a stall
        tick();
        #1 check("pre-reset stall", id_stall, 1);
        #2 rst_n = 1'b0;
        #1;
        check("areset ex_valid", ex_valid, 0);
        check("areset id_stall", id_stall, 0);
        check("areset stall_count", stall_count, 0);
        check("areset flush_count", flush_count, 0);
        check("areset ex_rd", ex_rd, 0);
        check("areset a0", a0, 0);
        #2 rst_n = 1'b1;
        tick();
        present(32'h0001_8433, 1'b1);
        tick();
        check("post-reset valid", ex_valid, 1);
        check("post-reset x3", ex_read_data1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
